bp_be_dcache_wbuf_queue: RTL and testbench

BP_BE_DCACHE_WBUF_QUEUE -- requirements
Module: bp_be_dcache_wbuf_queue

---
 rtl/bp_be_dcache_wbuf_queue.sv | 136 +++++++++++++
 tb/tb_bp_be_dcache_wbuf_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_dcache_wbuf_queue.sv
// Store write buffer: circular FIFO with youngest-entry write coalescing and load bypass.
// Latency 1: an accepted entry appears on v_o/bypass the cycle after the enqueue edge.
// Backpressure: ready_o drops when full unless the store merges into the youngest entry.
module bp_be_dcache_wbuf_queue #(
    parameter int data_width_p  = 64,
    parameter int paddr_width_p = 22,
    parameter int ways_p        = 8,
    parameter int depth_p       = 4,
    parameter int merge_p       = 1,
    localparam int mask_width_lp = data_width_p / 8,
    localparam int way_width_lp  = $clog2(ways_p),
    localparam int ptr_width_lp  = $clog2(depth_p),
    localparam int offset_lp     = $clog2(mask_width_lp)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    input  logic [paddr_width_p-1:0]  addr_i,
    input  logic [data_width_p-1:0]   data_i,
    input  logic [mask_width_lp-1:0]  mask_i,
    input  logic [way_width_lp-1:0]   way_id_i,
    output logic                      ready_o,
    output logic                      v_o,
    output logic [paddr_width_p-1:0]  addr_o,
    output logic [data_width_p-1:0]   data_o,
    output logic [mask_width_lp-1:0]  mask_o,
    output logic [way_width_lp-1:0]   way_id_o,
    input  logic                      yumi_i,
    output logic [ptr_width_lp:0]     count_o,
    input  logic                      bypass_v_i,
    input  logic [paddr_width_p-1:0]  bypass_addr_i,
    output logic [data_width_p-1:0]   bypass_data_o,
    output logic [mask_width_lp-1:0]  bypass_mask_o
);

    localparam logic [ptr_width_lp-1:0] ptr_one   = ptr_width_lp'(1);
    localparam logic [ptr_width_lp:0]   count_one = (ptr_width_lp+1)'(1);
    localparam logic [ptr_width_lp:0]   depth_lp  = (ptr_width_lp+1)'(depth_p);

    logic [paddr_width_p-1:0] addr_r [depth_p];
    logic [data_width_p-1:0]  data_r [depth_p];
    logic [mask_width_lp-1:0] mask_r [depth_p];
    logic [way_width_lp-1:0]  way_r  [depth_p];

    logic [ptr_width_lp-1:0] head_r, tail_r, young_idx;
    logic [ptr_width_lp:0]   count_r, count_next;
    logic                    young_match, merge_hit, enq, enq_alloc, enq_merge, deq;
    logic [data_width_p-1:0] merge_data;

    assign young_idx   = tail_r - ptr_one;
    assign young_match = addr_r[young_idx][paddr_width_p-1:offset_lp] == addr_i[paddr_width_p-1:offset_lp];
    // A lone entry leaving this cycle cannot absorb a store; it would be lost with the dequeue.
    assign merge_hit   = (merge_p != 0) && (count_r != '0) && young_match
                         && !((count_r == count_one) && yumi_i);

    assign ready_o   = (count_r < depth_lp) | merge_hit;
    assign enq       = v_i & ready_o;
    assign enq_merge = enq & merge_hit;
    assign enq_alloc = enq & ~merge_hit;
    assign v_o       = (count_r != '0);
    assign deq       = yumi_i & v_o;

    assign addr_o   = addr_r[head_r];
    assign data_o   = data_r[head_r];
    assign mask_o   = mask_r[head_r];
    assign way_id_o = way_r[head_r];
    assign count_o  = count_r;

    always_comb begin
        merge_data = data_r[young_idx];
        for (int b = 0; b < mask_width_lp; b++) begin
            if (mask_i[b]) merge_data[b*8 +: 8] = data_i[b*8 +: 8];
        end
    end

    always_comb begin
        count_next = count_r;
        case ({enq_alloc, deq})
            2'b10:   count_next = count_r + count_one;
            2'b01:   count_next = count_r - count_one;
            default: count_next = count_r;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < depth_p; i++) begin
                addr_r[i] <= '0;
                data_r[i] <= '0;
                mask_r[i] <= '0;
                way_r[i]  <= '0;
            end
        end else begin
            if (enq_alloc) begin
                addr_r[tail_r] <= addr_i;
                data_r[tail_r] <= data_i;
                mask_r[tail_r] <= mask_i;
                way_r[tail_r]  <= way_id_i;
                tail_r         <= tail_r + ptr_one;
            end else if (enq_merge) begin
                data_r[young_idx] <= merge_data;
                mask_r[young_idx] <= mask_r[young_idx] | mask_i;
                way_r[young_idx]  <= way_id_i;
            end
            if (deq) head_r <= head_r + ptr_one;
            count_r <= count_next;
        end
    end

    logic [ptr_width_lp-1:0] byp_idx;

    // Walk oldest to youngest so younger bytes overwrite older ones.
    always_comb begin
        bypass_data_o = '0;
        bypass_mask_o = '0;
        byp_idx       = '0;
        if (bypass_v_i) begin
            for (int i = 0; i < depth_p; i++) begin
                byp_idx = head_r + ptr_width_lp'(i);
                if (((ptr_width_lp+1)'(i) < count_r)
                    && (addr_r[byp_idx][paddr_width_p-1:offset_lp] == bypass_addr_i[paddr_width_p-1:offset_lp])) begin
                    for (int b = 0; b < mask_width_lp; b++) begin
                        if (mask_r[byp_idx][b]) begin
                            bypass_data_o[b*8 +: 8] = data_r[byp_idx][b*8 +: 8];
                            bypass_mask_o[b]        = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_be_dcache_wbuf_queue.sv
// Directed bench: dut[0] has merging disabled, dut[1] enabled; both see the same stimulus.
module tb_bp_be_dcache_wbuf_queue;

    logic        clk;
    logic        reset_n;
    logic        v;
    logic [21:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [2:0]  way;
    logic        yumi;
    logic        byp_v;
    logic [21:0] byp_addr;

    logic        rdy    [2];
    logic        vo     [2];
    logic [21:0] addr_o [2];
    logic [63:0] data_o [2];
    logic [7:0]  mask_o [2];
    logic [2:0]  way_o  [2];
    logic [2:0]  cnt    [2];
    logic [63:0] bdata  [2];
    logic [7:0]  bmask  [2];

    int checks = 0;
    int errors = 0;

    bp_be_dcache_wbuf_queue #(.data_width_p(64), .paddr_width_p(22), .ways_p(8), .depth_p(4), .merge_p(0)) dut0 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .addr_i(addr), .data_i(data), .mask_i(mask),
        .way_id_i(way), .ready_o(rdy[0]), .v_o(vo[0]), .addr_o(addr_o[0]), .data_o(data_o[0]),
        .mask_o(mask_o[0]), .way_id_o(way_o[0]), .yumi_i(yumi), .count_o(cnt[0]),
        .bypass_v_i(byp_v), .bypass_addr_i(byp_addr), .bypass_data_o(bdata[0]), .bypass_mask_o(bmask[0]));

    bp_be_dcache_wbuf_queue #(.data_width_p(64), .paddr_width_p(22), .ways_p(8), .depth_p(4), .merge_p(1)) dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .addr_i(addr), .data_i(data), .mask_i(mask),
        .way_id_i(way), .ready_o(rdy[1]), .v_o(vo[1]), .addr_o(addr_o[1]), .data_o(data_o[1]),
        .mask_o(mask_o[1]), .way_id_o(way_o[1]), .yumi_i(yumi), .count_o(cnt[1]),
        .bypass_v_i(byp_v), .bypass_addr_i(byp_addr), .bypass_data_o(bdata[1]), .bypass_mask_o(bmask[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Drive away from the rising edge; combinational outputs settle by the #1.
    task automatic drive(input logic vv, input logic [21:0] a, input logic [63:0] d,
                         input logic [7:0] m, input logic [2:0] w, input logic y);
        @(negedge clk);
        v = vv; addr = a; data = d; mask = m; way = w; yumi = y;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 22'h0, 64'h0, 8'h0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        v = 1'b0; yumi = 1'b0;
        tick();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        int          sel;
        logic        v;
        logic [21:0] a;
        logic [63:0] d;
        logic        yumi;
        logic        exp_rdy;
        int          exp_cnt;
        logic        exp_vo;
        logic [63:0] exp_head;
    } vec_t;

    vec_t tbl[10];
    logic [63:0] model[$];
    logic [63:0] nd;

    initial begin
        reset_n = 1'b0; v = 1'b0; addr = '0; data = '0; mask = '0; way = '0; yumi = 1'b0;
        byp_v = 1'b0; byp_addr = '0;

        tbl[0] = '{0, 1'b1, 22'h00, 64'hD0, 1'b0, 1'b1, 1, 1'b1, 64'hD0};
        tbl[1] = '{0, 1'b1, 22'h08, 64'hD1, 1'b0, 1'b1, 2, 1'b1, 64'hD0};
        tbl[2] = '{0, 1'b1, 22'h10, 64'hD2, 1'b0, 1'b1, 3, 1'b1, 64'hD0};
        tbl[3] = '{0, 1'b1, 22'h18, 64'hD3, 1'b0, 1'b1, 4, 1'b1, 64'hD0};
        tbl[4] = '{0, 1'b1, 22'h20, 64'hD4, 1'b0, 1'b0, 4, 1'b1, 64'hD0};
        tbl[5] = '{0, 1'b0, 22'h00, 64'h00, 1'b1, 1'b0, 3, 1'b1, 64'hD1};
        tbl[6] = '{0, 1'b0, 22'h00, 64'h00, 1'b1, 1'b1, 2, 1'b1, 64'hD2};
        tbl[7] = '{0, 1'b0, 22'h00, 64'h00, 1'b1, 1'b1, 1, 1'b1, 64'hD3};
        tbl[8] = '{0, 1'b0, 22'h00, 64'h00, 1'b1, 1'b1, 0, 1'b0, 64'h00};
        tbl[9] = '{0, 1'b0, 22'h00, 64'h00, 1'b1, 1'b1, 0, 1'b0, 64'h00};

        tick(); tick();
        @(negedge clk);
        reset_n = 1'b1;
        byp_v = 1'b1; byp_addr = 22'h0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_cnt%0d", s),   64'(cnt[s]),    64'd0);
            chk($sformatf("rst_vo%0d", s),    64'(vo[s]),     64'd0);
            chk($sformatf("rst_rdy%0d", s),   64'(rdy[s]),    64'd1);
            chk($sformatf("rst_addr%0d", s),  64'(addr_o[s]), 64'd0);
            chk($sformatf("rst_data%0d", s),  data_o[s],      64'd0);
            chk($sformatf("rst_mask%0d", s),  64'(mask_o[s]), 64'd0);
            chk($sformatf("rst_way%0d", s),   64'(way_o[s]),  64'd0);
            chk($sformatf("rst_bdata%0d", s), bdata[s],       64'd0);
            chk($sformatf("rst_bmask%0d", s), 64'(bmask[s]),  64'd0);
        end
        byp_v = 1'b0;

        // Fill and drain, no merging
        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].v, tbl[k].a, tbl[k].d, 8'hFF, 3'd0, tbl[k].yumi);
            chk($sformatf("fd%0d_rdy", k), 64'(rdy[tbl[k].sel]), 64'(tbl[k].exp_rdy));
            tick();
            chk($sformatf("fd%0d_cnt", k), 64'(cnt[tbl[k].sel]), 64'(tbl[k].exp_cnt));
            chk($sformatf("fd%0d_vo", k),  64'(vo[tbl[k].sel]),  64'(tbl[k].exp_vo));
            if (tbl[k].exp_vo) chk($sformatf("fd%0d_head", k), data_o[tbl[k].sel], tbl[k].exp_head);
        end
        idle();

        // Bypass priority: younger partial store overrides older full store
        do_reset();
        drive(1'b1, 22'h80, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 3'd0, 1'b0); tick();
        drive(1'b1, 22'h80, 64'h0000000055555555, 8'h0F, 3'd0, 1'b0); tick();
        idle();
        byp_v = 1'b1; byp_addr = 22'h80; #1;
        chk("byp_cnt0",   64'(cnt[0]),   64'd2);
        chk("byp_cnt1",   64'(cnt[1]),   64'd1);
        chk("byp_data0",  bdata[0],      64'hAAAAAAAA55555555);
        chk("byp_mask0",  64'(bmask[0]), 64'hFF);
        chk("byp_data1",  bdata[1],      64'hAAAAAAAA55555555);
        byp_addr = 22'h88; #1;
        chk("byp_miss_mask", 64'(bmask[0]), 64'h0);
        chk("byp_miss_data", bdata[0],      64'h0);
        byp_v = 1'b0; byp_addr = 22'h80; #1;
        chk("byp_off_mask", 64'(bmask[0]), 64'h0);
        chk("byp_off_data", bdata[0],      64'h0);
        byp_v = 1'b1; byp_addr = 22'h88;
        drive(1'b1, 22'h88, 64'h1234, 8'h03, 3'd0, 1'b0);
        chk("byp_same_cycle", 64'(bmask[0]), 64'h0);
        tick();
        chk("byp_next_mask", 64'(bmask[0]), 64'h03);
        chk("byp_next_data", bdata[0],      64'h1234);
        byp_v = 1'b0;
        idle();

        // Merge into youngest entry
        do_reset();
        drive(1'b1, 22'h40, 64'h11, 8'h01, 3'd3, 1'b0); tick();
        drive(1'b1, 22'h44, 64'h2200000000, 8'h10, 3'd5, 1'b0);
        chk("mrg_rdy", 64'(rdy[1]), 64'd1);
        tick();
        idle();
        chk("mrg_cnt1",  64'(cnt[1]),    64'd1);
        chk("mrg_mask",  64'(mask_o[1]), 64'h11);
        chk("mrg_data",  data_o[1],      64'h0000002200000011);
        chk("mrg_way",   64'(way_o[1]),  64'd5);
        chk("mrg_cnt0",  64'(cnt[0]),    64'd2);

        // Full with simultaneous events
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 22'(i * 8), 64'hF0 + 64'(i), 8'hFF, 3'd0, 1'b0); tick();
        end
        idle();
        chk("full_cnt", 64'(cnt[1]), 64'd4);
        chk("full_rdy", 64'(rdy[1]), 64'd0);
        drive(1'b1, 22'h100, 64'hBAD, 8'hFF, 3'd0, 1'b1);
        chk("full_nm_rdy", 64'(rdy[1]), 64'd0);
        tick();
        chk("full_nm_cnt",  64'(cnt[1]), 64'd3);
        chk("full_nm_head", data_o[1],   64'hF1);
        drive(1'b1, 22'h20, 64'hF4, 8'hFF, 3'd0, 1'b0); tick();
        chk("full_refill", 64'(cnt[1]), 64'd4);
        drive(1'b1, 22'h20, 64'hAB00, 8'h02, 3'd0, 1'b1);
        chk("full_m_rdy", 64'(rdy[1]), 64'd1);
        tick();
        idle();
        chk("full_m_cnt",  64'(cnt[1]), 64'd3);
        chk("full_m_head", data_o[1],   64'hF2);
        byp_v = 1'b1; byp_addr = 22'h20; #1;
        chk("full_m_byp", bdata[1], 64'hABF4);
        byp_v = 1'b0;

        // Wrap pointers with simultaneous enqueue/dequeue, then reset mid-flight
        do_reset();
        model.delete();
        for (int i = 0; i < 2; i++) begin
            nd = 64'h100 + 64'(i);
            drive(1'b1, 22'(i * 8), nd, 8'hFF, 3'd0, 1'b0); tick();
            model.push_back(nd);
        end
        for (int i = 2; i < 12; i++) begin
            nd = 64'h100 + 64'(i);
            drive(1'b1, 22'(i * 8), nd, 8'hFF, 3'd0, 1'b1);
            chk($sformatf("wrap%0d_head", i), data_o[0], model[0]);
            tick();
            void'(model.pop_front());
            model.push_back(nd);
            chk($sformatf("wrap%0d_cnt", i), 64'(cnt[0]), 64'd2);
        end
        drive(1'b1, 22'h200, 64'h999, 8'hFF, 3'd0, 1'b0); tick();
        chk("wrap_cnt3", 64'(cnt[0]), 64'd3);
        @(negedge clk);
        reset_n = 1'b0; v = 1'b1; yumi = 1'b1; addr = 22'h208; data = 64'h777;
        tick();
        reset_n = 1'b1;
        chk("rst2_cnt",  64'(cnt[0]), 64'd0);
        chk("rst2_vo",   64'(vo[0]),  64'd0);
        chk("rst2_rdy",  64'(rdy[0]), 64'd1);
        chk("rst2_data", data_o[0],   64'd0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
